// File: rtl/cirno_exec_core_if.sv
// Handshake/data bundle between the cirno step sequencer and the execution core.
// The sequencer drives strobes and operands; the core returns decode, ALU and memory results.
interface cirno_exec_core_if;
  logic       decoder_en;
  logic [8:0] inst;
  logic       alu_en;
  logic [7:0] x;
  logic [7:0] y;
  logic       cmp;
  logic       memory_r_en;
  logic       memory_w_en;

  logic [2:0] inst_type;
  logic [3:0] funct;
  logic [1:0] r1;
  logic [1:0] r2;
  logic [5:0] immediate;
  logic       y_is_imm;
  logic       is_cmp;
  logic       branch;
  logic       branchi;
  logic       jump;
  logic       done;
  logic [7:0] result;
  logic       eq;
  logic [7:0] mem_out;

  modport master (
    output decoder_en, inst, alu_en, x, y, cmp, memory_r_en, memory_w_en,
    input  inst_type, funct, r1, r2, immediate, y_is_imm, is_cmp,
           branch, branchi, jump, done, result, eq, mem_out
  );

  modport slave (
    input  decoder_en, inst, alu_en, x, y, cmp, memory_r_en, memory_w_en,
    output inst_type, funct, r1, r2, immediate, y_is_imm, is_cmp,
           branch, branchi, jump, done, result, eq, mem_out
  );
endinterface

// File: rtl/cirno_exec_core.sv
// cirno 8-bit CPU execution core: registered 9-bit decoder, 8-bit ALU and synchronous data memory.
// Each stage updates only on its own strobe from the step sequencer; init clears every output.
module cirno_exec_core #(
  parameter int DMEM_DEPTH = 256
) (
  input  logic             clk,
  input  logic             init,
  cirno_exec_core_if.slave bus
);

  localparam int AW = $clog2(DMEM_DEPTH);

  localparam logic [2:0] T_ALU  = 3'd1;
  localparam logic [2:0] T_IMMB = 3'd2;
  localparam logic [2:0] T_MOVE = 3'd3;
  localparam logic [2:0] T_REGB = 3'd4;
  localparam logic [2:0] T_ST   = 3'd5;
  localparam logic [2:0] T_LD   = 3'd6;

  // Shift amounts of 8 or more flush every bit out.
  function automatic logic [7:0] shl_sat(input logic [7:0] a, input logic [7:0] n);
    return (n >= 8'd8) ? 8'h00 : (a << n[2:0]);
  endfunction

  function automatic logic [7:0] shr_sat(input logic [7:0] a, input logic [7:0] n);
    return (n >= 8'd8) ? 8'h00 : (a >> n[2:0]);
  endfunction

  // Bidirectional shift: negative amount shifts right logically by its magnitude.
  function automatic logic [7:0] sh_signed(input logic [7:0] a, input logic [7:0] b);
    logic signed [7:0] bs;
    bs = signed'(b);
    if (bs < 8'sd0) return shr_sat(a, 8'(-bs));
    else            return shl_sat(a, b);
  endfunction

  // Decode stage p0: combinational decode of the incoming instruction word
  logic [2:0] type_p0;
  logic [3:0] funct_p0;
  logic [1:0] r1_p0, r2_p0;
  logic [5:0] imm_p0;
  logic       yimm_p0, iscmp_p0, br_p0, bri_p0, jmp_p0, halt_p0;

  always_comb begin
    type_p0  = 3'd0;
    funct_p0 = 4'd0;
    r1_p0    = 2'd0;
    r2_p0    = 2'd0;
    imm_p0   = 6'd0;
    yimm_p0  = 1'b0;
    iscmp_p0 = 1'b0;
    br_p0    = 1'b0;
    bri_p0   = 1'b0;
    jmp_p0   = 1'b0;
    halt_p0  = 1'b0;
    if (!bus.inst[8]) begin
      funct_p0 = bus.inst[7:4];
      r1_p0    = bus.inst[3:2];
      r2_p0    = bus.inst[1:0];
      case (bus.inst[7:4])
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7: type_p0 = T_ALU;
        4'd6: begin
          type_p0  = T_ALU;
          iscmp_p0 = 1'b1;
        end
        4'd8, 4'd9, 4'd10: begin
          type_p0 = T_ALU;
          yimm_p0 = 1'b1;
          imm_p0  = {4'b0, bus.inst[1:0]};
        end
        4'd11: type_p0 = T_MOVE;
        4'd12: begin
          type_p0 = T_REGB;
          jmp_p0  = 1'b1;
        end
        4'd13: begin
          type_p0 = T_REGB;
          br_p0   = 1'b1;
        end
        4'd14: type_p0 = T_ST;
        default: type_p0 = T_LD;
      endcase
    end else if (bus.inst == 9'h1FF) begin
      // Halt shares the beqi opcode space but raises no branch flag.
      type_p0 = T_IMMB;
      imm_p0  = bus.inst[5:0];
      halt_p0 = 1'b1;
    end else begin
      case (bus.inst[7:6])
        2'b00, 2'b01: begin
          type_p0  = T_MOVE;
          r1_p0    = bus.inst[5:4];
          imm_p0   = {2'b0, bus.inst[3:0]};
          funct_p0 = {3'b0, bus.inst[6]};
        end
        2'b10: begin
          type_p0 = T_IMMB;
          imm_p0  = bus.inst[5:0];
          jmp_p0  = 1'b1;
        end
        default: begin
          type_p0 = T_IMMB;
          imm_p0  = bus.inst[5:0];
          bri_p0  = 1'b1;
        end
      endcase
    end
  end

  // Decode stage p1: registered decoder outputs
  logic [2:0] type_p1;
  logic [3:0] funct_p1;
  logic [1:0] r1_p1, r2_p1;
  logic [5:0] imm_p1;
  logic       yimm_p1, iscmp_p1, br_p1, bri_p1, jmp_p1, done_p1;

  always_ff @(posedge clk) begin
    if (init) begin
      type_p1  <= 3'd0;
      funct_p1 <= 4'd0;
      r1_p1    <= 2'd0;
      r2_p1    <= 2'd0;
      imm_p1   <= 6'd0;
      yimm_p1  <= 1'b0;
      iscmp_p1 <= 1'b0;
      br_p1    <= 1'b0;
      bri_p1   <= 1'b0;
      jmp_p1   <= 1'b0;
      done_p1  <= 1'b0;
    end else if (bus.decoder_en) begin
      type_p1  <= type_p0;
      funct_p1 <= funct_p0;
      r1_p1    <= r1_p0;
      r2_p1    <= r2_p0;
      imm_p1   <= imm_p0;
      yimm_p1  <= yimm_p0;
      iscmp_p1 <= iscmp_p0;
      br_p1    <= br_p0;
      bri_p1   <= bri_p0;
      jmp_p1   <= jmp_p0;
      done_p1  <= done_p1 | halt_p0;
    end
  end

  // ALU stage p1: combinational result from registered decode and live operands
  logic [7:0] b_p1;
  logic [7:0] res_p1;
  logic       eq_p1;

  always_comb begin
    b_p1  = yimm_p1 ? {2'b0, imm_p1} : bus.y;
    eq_p1 = (bus.x == b_p1);
    case (funct_p1)
      4'd0:    res_p1 = bus.x + b_p1;
      4'd1:    res_p1 = bus.x - b_p1;
      4'd2:    res_p1 = bus.x & b_p1;
      4'd3:    res_p1 = bus.x | b_p1;
      4'd4:    res_p1 = bus.x ^ b_p1;
      4'd5:    res_p1 = sh_signed(bus.x, b_p1);
      4'd6:    res_p1 = bus.x;
      4'd7:    res_p1 = bus.x + {7'b0, bus.cmp};
      4'd8:    res_p1 = bus.x & b_p1;
      4'd9:    res_p1 = shr_sat(bus.x, b_p1);
      4'd10:   res_p1 = shl_sat(bus.x, b_p1);
      default: res_p1 = b_p1;
    endcase
  end

  // ALU stage p2: registered result and equality flag
  logic [7:0] res_p2;
  logic       eq_p2;

  always_ff @(posedge clk) begin
    if (init) begin
      res_p2 <= 8'h00;
      eq_p2  <= 1'b0;
    end else if (bus.alu_en) begin
      res_p2 <= res_p1;
      eq_p2  <= eq_p1;
    end
  end

  // Memory stage: array is never cleared; writes are blocked while init is high
  logic [7:0]    mem [DMEM_DEPTH];
  logic [AW-1:0] addr;
  logic [7:0]    mem_out_p1;

  assign addr = bus.y[AW-1:0];

  always_ff @(posedge clk) begin
    if (!init && bus.memory_w_en) mem[addr] <= bus.x;
  end

  // Non-blocking read of the same array gives read-first behaviour on collisions.
  always_ff @(posedge clk) begin
    if (init)                  mem_out_p1 <= 8'h00;
    else if (bus.memory_r_en)  mem_out_p1 <= mem[addr];
  end

  assign bus.inst_type = type_p1;
  assign bus.funct     = funct_p1;
  assign bus.r1        = r1_p1;
  assign bus.r2        = r2_p1;
  assign bus.immediate = imm_p1;
  assign bus.y_is_imm  = yimm_p1;
  assign bus.is_cmp    = iscmp_p1;
  assign bus.branch    = br_p1;
  assign bus.branchi   = bri_p1;
  assign bus.jump      = jmp_p1;
  assign bus.done      = done_p1;
  assign bus.result    = res_p2;
  assign bus.eq        = eq_p2;
  assign bus.mem_out   = mem_out_p1;

endmodule

// File: tb/tb_cirno_exec_core.sv
// Directed bench for cirno_exec_core: expectations are queued as stimulus is driven
// and compared against the DUT outputs one cycle later.
module tb_cirno_exec_core;

  logic clk;
  logic init;
  cirno_exec_core_if bus();

  cirno_exec_core #(.DMEM_DEPTH(256)) dut (
    .clk  (clk),
    .init (init),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int unsigned exp;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  function automatic int unsigned observe(input string tag);
    case (tag)
      "inst_type": return {29'd0, bus.inst_type};
      "funct":     return {28'd0, bus.funct};
      "r1":        return {30'd0, bus.r1};
      "r2":        return {30'd0, bus.r2};
      "immediate": return {26'd0, bus.immediate};
      "y_is_imm":  return {31'd0, bus.y_is_imm};
      "is_cmp":    return {31'd0, bus.is_cmp};
      "branch":    return {31'd0, bus.branch};
      "branchi":   return {31'd0, bus.branchi};
      "jump":      return {31'd0, bus.jump};
      "done":      return {31'd0, bus.done};
      "result":    return {24'd0, bus.result};
      "eq":        return {31'd0, bus.eq};
      "mem_out":   return {24'd0, bus.mem_out};
      default:     return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic sb_push(input string tag, input int unsigned v);
    sb_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    sb_t         e;
    int unsigned obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.tag);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic push_all_zero();
    sb_push("inst_type", 0); sb_push("funct", 0);     sb_push("r1", 0);
    sb_push("r2", 0);        sb_push("immediate", 0); sb_push("y_is_imm", 0);
    sb_push("is_cmp", 0);    sb_push("branch", 0);    sb_push("branchi", 0);
    sb_push("jump", 0);      sb_push("done", 0);      sb_push("result", 0);
    sb_push("eq", 0);        sb_push("mem_out", 0);
  endtask

  task automatic dec(input logic [8:0] i, input int unsigned typ, input int unsigned fn,
                     input int unsigned a, input int unsigned b, input int unsigned imm,
                     input int unsigned yi, input int unsigned ic, input int unsigned br,
                     input int unsigned bi, input int unsigned jp, input int unsigned dn);
    bus.inst       = i;
    bus.decoder_en = 1'b1;
    sb_push("inst_type", typ); sb_push("funct", fn);      sb_push("r1", a);
    sb_push("r2", b);          sb_push("immediate", imm); sb_push("y_is_imm", yi);
    sb_push("is_cmp", ic);     sb_push("branch", br);     sb_push("branchi", bi);
    sb_push("jump", jp);       sb_push("done", dn);
    step();
    bus.decoder_en = 1'b0;
  endtask

  task automatic alu(input logic [7:0] xa, input logic [7:0] ya, input logic c,
                     input int unsigned res, input int unsigned eqv);
    bus.x      = xa;
    bus.y      = ya;
    bus.cmp    = c;
    bus.alu_en = 1'b1;
    sb_push("result", res);
    sb_push("eq", eqv);
    step();
    bus.alu_en = 1'b0;
  endtask

  task automatic mem(input logic w, input logic r, input logic [7:0] addr,
                     input logic [7:0] data, input int unsigned exp_out);
    bus.memory_w_en = w;
    bus.memory_r_en = r;
    bus.y           = addr;
    bus.x           = data;
    sb_push("mem_out", exp_out);
    step();
    bus.memory_w_en = 1'b0;
    bus.memory_r_en = 1'b0;
  endtask

  initial begin
    init            = 1'b1;
    bus.decoder_en  = 1'b0;
    bus.inst        = 9'h000;
    bus.alu_en      = 1'b0;
    bus.x           = 8'h00;
    bus.y           = 8'h00;
    bus.cmp         = 1'b0;
    bus.memory_r_en = 1'b0;
    bus.memory_w_en = 1'b0;

    // Reset state
    push_all_zero();
    step();
    init = 1'b0;

    // Decode of add r1=1 r2=2, then hold with decoder_en low
    dec(9'h006, 1, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    bus.inst = 9'h1FF;
    sb_push("inst_type", 1); sb_push("r2", 2); sb_push("done", 0);
    step();

    // ALU arithmetic
    alu(8'hFF, 8'h02, 1'b0, 8'h01, 0);
    dec(9'h010, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    alu(8'h03, 8'h05, 1'b0, 8'hFE, 0);

    // Signed shift, including the >=8 and -128 flush cases
    dec(9'h050, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    alu(8'h81, 8'hFF, 1'b0, 8'h40, 0);
    alu(8'h81, 8'h09, 1'b0, 8'h00, 0);
    alu(8'h01, 8'h03, 1'b0, 8'h08, 0);
    alu(8'hFF, 8'hF8, 1'b0, 8'h00, 0);
    alu(8'hFF, 8'h80, 1'b0, 8'h00, 0);

    // Immediate ALU ops
    dec(9'h0A3, 1, 10, 0, 3, 3, 1, 0, 0, 0, 0, 0);
    alu(8'h01, 8'h55, 1'b0, 8'h08, 0);
    dec(9'h092, 1, 9, 0, 2, 2, 1, 0, 0, 0, 0, 0);
    alu(8'h80, 8'h55, 1'b0, 8'h20, 0);
    dec(9'h083, 1, 8, 0, 3, 3, 1, 0, 0, 0, 0, 0);
    alu(8'hFF, 8'h00, 1'b0, 8'h03, 0);
    alu(8'h03, 8'h00, 1'b0, 8'h03, 1);

    // cmp and incc
    dec(9'h060, 1, 6, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    alu(8'h07, 8'h07, 1'b0, 8'h07, 1);
    alu(8'h07, 8'h08, 1'b0, 8'h07, 0);
    dec(9'h070, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    alu(8'hFF, 8'h00, 1'b1, 8'h00, 0);
    alu(8'hFF, 8'h00, 1'b0, 8'hFF, 0);

    // Logic ops and result hold
    dec(9'h040, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    alu(8'hF0, 8'h3C, 1'b0, 8'hCC, 0);
    bus.x = 8'h00;
    sb_push("result", 8'hCC);
    step();
    dec(9'h030, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    alu(8'hF0, 8'h0F, 1'b0, 8'hFF, 0);

    // Memory: write, read, read-first collision, hold
    mem(1'b1, 1'b0, 8'h10, 8'hA5, 8'h00);
    mem(1'b0, 1'b1, 8'h10, 8'h00, 8'hA5);
    mem(1'b1, 1'b1, 8'h10, 8'h3C, 8'hA5);
    mem(1'b0, 1'b1, 8'h10, 8'h00, 8'h3C);
    mem(1'b0, 1'b0, 8'h11, 8'h00, 8'h3C);

    // Remaining register-form types
    dec(9'h0B6, 3, 11, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    dec(9'h0C0, 4, 12, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    dec(9'h0D0, 4, 13, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    dec(9'h0E0, 5, 14, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    dec(9'h0F0, 6, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Immediate-form types
    dec(9'h11A, 3, 0, 1, 0, 8'h0A, 0, 0, 0, 0, 0, 0);
    dec(9'h165, 3, 1, 2, 0, 8'h05, 0, 0, 0, 0, 0, 0);
    dec(9'h1AA, 2, 0, 0, 0, 8'h2A, 0, 0, 0, 0, 1, 0);
    dec(9'h1C5, 2, 0, 0, 0, 8'h05, 0, 0, 0, 1, 0, 0);

    // Halt is sticky across later decodes
    dec(9'h1FF, 2, 0, 0, 0, 8'h3F, 0, 0, 0, 0, 0, 1);
    dec(9'h006, 1, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1);

    // init wins over every strobe in the same cycle
    bus.inst        = 9'h1C5;
    bus.decoder_en  = 1'b1;
    bus.alu_en      = 1'b1;
    bus.x           = 8'h77;
    bus.y           = 8'h10;
    bus.memory_w_en = 1'b1;
    bus.memory_r_en = 1'b1;
    init            = 1'b1;
    push_all_zero();
    step();
    init            = 1'b0;
    bus.decoder_en  = 1'b0;
    bus.alu_en      = 1'b0;
    bus.memory_w_en = 1'b0;
    bus.memory_r_en = 1'b0;

    // Memory contents survive init and the blocked write
    mem(1'b0, 1'b1, 8'h10, 8'h00, 8'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
